pos_cell_ctrl: RTL

POS_CELL_CTRL -- requirements
Module: pos_cell_ctrl

---
 rtl/pos_cell_pkg.sv | 12 +
 rtl/pos_cell_rd_tag.sv | 21 ++
 rtl/pos_cell_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/pos_cell_pkg.sv
// pos_cell_pkg: shared state encoding, read-tag record and RAM latency for the cell controller
package pos_cell_pkg;
  localparam int RAM_RD_LAT = 2;
  localparam int CELL_IDX_W = 8;
  typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN} state_e;
  typedef struct packed {
    logic                  valid;
    logic                  is_count;
    logic [CELL_IDX_W-1:0] index;
    logic                  last;
  } rd_tag_t;
endpackage

// File: rtl/pos_cell_rd_tag.sv
// pos_cell_rd_tag: delays each read's tag by the RAM read latency so it lines up with mem_q
module pos_cell_rd_tag
  import pos_cell_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);
  rd_tag_t pipe_q [RAM_RD_LAT];
  // shift the tag one stage per cycle; reset drops every in-flight read
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RAM_RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < RAM_RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign tag_o = pipe_q[RAM_RD_LAT-1];
endmodule

// File: rtl/pos_cell_ctrl.sv
// pos_cell_ctrl: streams one cell's particles out of RAM while sharing the port with motion-update writes
module pos_cell_ctrl
  import pos_cell_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_start,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] count_q, addr_q;
  logic                  wr_turn_q;
  logic                  rd_phase, rd_issue, cnt_ret, part_ret;
  logic [ADDR_WIDTH-1:0] rd_addr, cnt_raw, cnt_clamp;
  rd_tag_t               tag_in, tag_out;
  // wr_turn_q says the write owns the next contended slot, so reads and writes alternate under pressure
  assign rd_phase    = state_q == RD_CNT || state_q == STREAM;
  assign wr_gnt      = !rst && wr_req && (!rd_phase || wr_turn_q);
  assign rd_issue    = !rst && rd_phase && !wr_gnt;
  assign rd_addr     = state_q == RD_CNT ? '0 : addr_q;
  assign mem_wren    = wr_gnt;
  assign mem_rden    = rd_issue;
  assign mem_address = wr_gnt ? wr_addr : rd_issue ? rd_addr : '0;
  assign mem_data    = wr_gnt ? wr_data : '0;
  assign tag_in      = '{valid: rd_issue, is_count: state_q == RD_CNT, index: CELL_IDX_W'(rd_addr),
                         last: state_q == STREAM && addr_q == count_q};
  pos_cell_rd_tag u_tag (.clk(clk), .rst(rst), .tag_i(tag_in), .tag_o(tag_out));
  assign cnt_ret   = !rst && tag_out.valid && tag_out.is_count;
  assign part_ret  = !rst && tag_out.valid && !tag_out.is_count;
  assign cnt_raw   = mem_q[ADDR_WIDTH-1:0];
  assign cnt_clamp = cnt_raw > MAX_CNT ? MAX_CNT : cnt_raw;
  assign out_valid = part_ret;
  assign out_data  = mem_q;
  assign out_index = ADDR_WIDTH'(tag_out.index);
  assign out_last  = part_ret && tag_out.last;
  assign done      = (cnt_ret && cnt_clamp == '0) || out_last;
  assign busy      = !rst && state_q != IDLE;
  // sequencer: fetch the count, issue particle reads 1..count, then wait for the last word to return
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      addr_q    <= '0;
      wr_turn_q <= 1'b1;
    end else begin
      wr_turn_q <= !rd_phase ? 1'b1 : wr_gnt ? 1'b0 : rd_issue ? 1'b1 : wr_turn_q;
      case (state_q)
        IDLE:     if (rd_start) state_q <= RD_CNT;
        RD_CNT:   if (rd_issue) state_q <= WAIT_CNT;
        WAIT_CNT: if (cnt_ret) begin
          count_q <= cnt_clamp;
          addr_q  <= ADDR_WIDTH'(1);
          state_q <= cnt_clamp == '0 ? IDLE : STREAM;
        end
        STREAM:   if (rd_issue) begin
          addr_q  <= addr_q + 1'b1;
          if (addr_q == count_q) state_q <= DRAIN;
        end
        DRAIN:    if (out_last) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end
endmodule
